seq_rate_timer: RTL and testbench

- Parametrised tick generator for sequence playback timing. It produces one-cycle `tick` pulses at a selectable fraction of `CLOCK_FREQUENCY` cycles.
- Adds over the previous divider: speed latched internally, wider power-of-two speed range, pause/resume, stop, tick counting, and a finite one-shot mode that signals `done` after N ticks.
- Sits between the game FSM and the LED/sequence-display logic.

---
 rtl/seq_rate_timer.sv | 100 ++++++++++
 tb/tb_seq_rate_timer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_rate_timer.sv
// Sequence playback tick generator: one-cycle tick every ceil(CLOCK_FREQUENCY/step)
// running cycles, with pause/resume, abort, tick counting and an optional one-shot limit.
module seq_rate_timer #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int SPEED_W         = 3,
  parameter int TICK_W          = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [SPEED_W-1:0] speed,
  input  logic [TICK_W-1:0]  tick_limit,
  output logic               tick,
  output logic               done,
  output logic               busy,
  output logic [TICK_W-1:0]  tick_count
);

  // Headroom for the largest step (2^(2^SPEED_W-2)) on top of an accumulator below CLOCK_FREQUENCY.
  localparam int ACC_W = $clog2(CLOCK_FREQUENCY) + 2**SPEED_W;
  localparam logic [ACC_W-1:0] FREQ = ACC_W'(CLOCK_FREQUENCY);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

  logic [1:0]         state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   step;
  logic [ACC_W-1:0]   acc_sum;
  logic [SPEED_W-1:0] spd_q;
  logic [TICK_W-1:0]  lim_q;
  logic [TICK_W-1:0]  cnt_next;
  logic               start_ok;

  assign start_ok = start && (speed != '0);
  assign step     = ACC_W'(1) << (spd_q - SPEED_W'(1));
  assign acc_sum  = acc + step;
  assign cnt_next = tick_count + TICK_W'(1);

  // NOTE: every register here is written with <= so all updates see pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      acc        <= '0;
      tick_count <= '0;
      spd_q      <= '0;
      lim_q      <= '0;
      tick       <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (start_ok) begin
        spd_q      <= speed;
        lim_q      <= tick_limit;
        acc        <= '0;
        tick_count <= '0;
        state      <= ST_RUN;
        busy       <= 1'b1;
      end else if (stop) begin
        // tick_count is left alone so the host can read how far playback got.
        state <= ST_IDLE;
        acc   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_RUN, ST_PAUSED: begin
            if (pause) begin
              state <= ST_PAUSED;
            end else begin
              state <= ST_RUN;
              if (acc_sum >= FREQ) begin
                acc        <= '0;
                tick       <= 1'b1;
                tick_count <= cnt_next;
                if (lim_q != '0 && cnt_next == lim_q) begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                acc <= acc_sum;
              end
            end
          end
          ST_IDLE: ;
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_rate_timer.sv
// Bench for seq_rate_timer: two instances (F=8/TICK_W=8 and F=7/TICK_W=2) scored
// against a period-counting reference model, plus directed interval measurements.
module tb_seq_rate_timer;

  typedef struct {
    int tick;
    int done;
    int busy;
    int cnt;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset, start, stop, pause;
  logic [2:0] speed;
  logic [7:0] tick_limit;

  logic       tick0, done0, busy0;
  logic [7:0] cnt0;
  logic       tick1, done1, busy1;
  logic [1:0] cnt1;

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: counts unpaused running cycles against the nominal period.
  int m_busy[2];
  int m_el[2];
  int m_per[2];
  int m_cnt[2];
  int m_lim[2];

  always #5 clock = ~clock;

  seq_rate_timer #(.CLOCK_FREQUENCY(8), .SPEED_W(3), .TICK_W(8)) dut0 (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .speed(speed), .tick_limit(tick_limit),
    .tick(tick0), .done(done0), .busy(busy0), .tick_count(cnt0)
  );

  seq_rate_timer #(.CLOCK_FREQUENCY(7), .SPEED_W(3), .TICK_W(2)) dut1 (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .speed(speed), .tick_limit(tick_limit[1:0]),
    .tick(tick1), .done(done1), .busy(busy1), .tick_count(cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input int f, input int tw, output exp_t e);
    int step;
    e.tick = 0;
    e.done = 0;
    if (reset) begin
      m_busy[i] = 0; m_el[i] = 0; m_per[i] = 0; m_cnt[i] = 0; m_lim[i] = 0;
    end else if (start && speed != 0) begin
      step      = 1 << (int'(speed) - 1);
      m_per[i]  = (f + step - 1) / step;
      m_lim[i]  = int'(tick_limit) % (1 << tw);
      m_el[i]   = 0;
      m_cnt[i]  = 0;
      m_busy[i] = 1;
    end else if (stop) begin
      m_busy[i] = 0;
      m_el[i]   = 0;
    end else if (m_busy[i] != 0 && !pause) begin
      m_el[i]++;
      if (m_el[i] == m_per[i]) begin
        m_el[i]  = 0;
        m_cnt[i] = (m_cnt[i] + 1) % (1 << tw);
        e.tick   = 1;
        if (m_lim[i] != 0 && m_cnt[i] == m_lim[i]) begin
          e.done    = 1;
          m_busy[i] = 0;
        end
      end
    end
    e.busy = m_busy[i];
    e.cnt  = m_cnt[i];
  endtask

  always @(posedge clock) begin : model
    exp_t e;
    model_step(0, 8, 8, e);
    q0.push_back(e);
    model_step(1, 7, 2, e);
    q1.push_back(e);
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      check("d0.tick", tick0, e.tick);
      check("d0.done", done0, e.done);
      check("d0.busy", busy0, e.busy);
      check("d0.tick_count", cnt0, e.cnt);
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      check("d1.tick", tick1, e.tick);
      check("d1.done", done1, e.done);
      check("d1.busy", busy1, e.busy);
      check("d1.tick_count", cnt1, e.cnt);
    end
  end

  task automatic pulse_start(input int s, input int l);
    speed      = 3'(s);
    tick_limit = 8'(l);
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Counts negedges until the chosen instance shows tick; bounded.
  task automatic wait_tick(input int inst, output int gap);
    logic t;
    gap = 0;
    do begin
      @(negedge clock);
      gap++;
      t = (inst == 0) ? tick0 : tick1;
    end while (t !== 1'b1 && gap < 200);
    if (t !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: inst %0d saw no tick within %0d cycles", inst, gap);
    end
  endtask

  initial begin
    int   g, g2;
    logic seen;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    speed = '0; tick_limit = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Free-run, step 1: 8-cycle period; speed input changes are ignored mid-run.
    pulse_start(1, 0);
    wait_tick(0, g); check("first_tick_delay", g, 8);
    wait_tick(0, g); check("period_spd1", g, 8);
    speed = 3'd3;
    wait_tick(0, g); check("speed_change_ignored", g, 8);
    check("count_after_24", cnt0, 3);
    check("free_run_no_done", done0, 0);

    // Pause 5 cycles, raised 4 cycles after a tick.
    g = 0; seen = 1'b0;
    repeat (3) begin @(negedge clock); g++; seen = seen | tick0; end
    pause = 1'b1;
    repeat (5) begin @(negedge clock); g++; seen = seen | tick0; end
    pause = 1'b0;
    wait_tick(0, g2);
    check("pause_gap", g + g2, 13);
    check("no_tick_while_paused", seen, 0);

    // One-shot of three ticks (also a clean restart from RUN).
    pulse_start(1, 3);
    wait_tick(0, g); check("oneshot_gap1", g, 8);
    wait_tick(0, g); check("oneshot_gap2", g, 8);
    wait_tick(0, g); check("oneshot_gap3", g, 8);
    check("oneshot_done", done0, 1);
    check("oneshot_count", cnt0, 3);
    @(negedge clock);
    check("oneshot_busy_low", busy0, 0);
    seen = 1'b0;
    repeat (20) begin @(negedge clock); seen = seen | tick0; end
    check("oneshot_silent", seen, 0);
    check("oneshot_count_held", cnt0, 3);

    // stop and start together: start wins and the period restarts.
    pulse_start(1, 0);
    repeat (5) @(negedge clock);
    stop = 1'b1; start = 1'b1; speed = 3'd1;
    @(negedge clock);
    stop = 1'b0; start = 1'b0;
    wait_tick(0, g); check("restart_gap", g, 8);
    check("restart_count", cnt0, 1);
    repeat (3) @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check("stop_busy", busy0, 0);
    check("stop_count_held", cnt0, 1);

    // step 4 at F=8 -> period 2; step 2 at F=7 -> period 4.
    pulse_start(3, 0);
    wait_tick(0, g); check("period_spd3", g, 2);
    wait_tick(0, g); check("period_spd3_b", g, 2);
    pulse_start(2, 0);
    wait_tick(1, g); check("f7_period_spd2", g, 4);
    wait_tick(1, g); check("f7_period_spd2_b", g, 4);

    // Reset mid-run with a non-zero accumulator.
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_tick", tick0, 0);
    check("rst_done", done0, 0);
    check("rst_busy", busy0, 0);
    check("rst_count", cnt0, 0);

    // speed 0 start is ignored.
    pulse_start(0, 5);
    check("speed0_ignored", busy0, 0);

    // Randomized traffic, scored by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      start      = ($urandom_range(0, 39) == 0);
      stop       = ($urandom_range(0, 59) == 0);
      reset      = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      speed      = 3'($urandom_range(0, 7));
      tick_limit = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
    end
    @(negedge clock);
    start = 1'b0; stop = 1'b0; reset = 1'b0; pause = 1'b0;
    repeat (4) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
